// File: rtl/eh2_posit_pkg.sv
// Shared posit types and constant helpers for the EH2 posit datapath.
package eh2_posit_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_NAR    = 2'd2
  } posit_cls_e;

  localparam int POSIT_MAX_LEN = 64;

  function automatic int posit_rw(input int len);
    return $clog2(len) + 1;
  endfunction

  function automatic logic [POSIT_MAX_LEN-1:0] posit_maxpos(input int len);
    return (POSIT_MAX_LEN'(1) << (len - 1)) - POSIT_MAX_LEN'(1);
  endfunction

  // A 1-bit posit has no representable minpos.
  function automatic logic [POSIT_MAX_LEN-1:0] posit_minpos(input int len);
    return POSIT_MAX_LEN'(len > 1);
  endfunction

  function automatic logic [POSIT_MAX_LEN-1:0] posit_nar(input int len);
    return POSIT_MAX_LEN'(1) << (len - 1);
  endfunction

endpackage

// File: rtl/eh2_posit_round_rne.sv
// Round-to-nearest-even on the posit body; clamps to maxpos/minpos so the
// rounded body can never alias zero or NaR.
module eh2_posit_round_rne #(
  parameter int BW = 31
) (
  input  logic [BW-1:0] body,
  input  logic          guard,
  input  logic          sticky,
  output logic [BW-1:0] body_rnd,
  output logic          sat
);

  logic [BW:0] sum;
  logic        inc;

  always_comb begin
    inc      = guard & (body[0] | sticky);
    sum      = {1'b0, body} + {{BW{1'b0}}, inc};
    body_rnd = sum[BW-1:0];
    sat      = 1'b0;
    if (sum[BW]) begin
      body_rnd = '1;
      sat      = 1'b1;
    end else if (sum[BW-1:0] == '0) begin
      body_rnd = {{(BW-1){1'b0}}, 1'b1};
      sat      = 1'b1;
    end
  end

endmodule

// File: rtl/eh2_posit_encode_pipe.sv
// Two-stage valid/ready posit encoder: S1 packs regime/exp/frac, S2 rounds.
// EH2_POSIT_SATURATE_EN selects saturating over/underflow instead of NaR.
module eh2_posit_encode_pipe
  import eh2_posit_pkg::*;
#(
  parameter int POSIT_LEN = 32,
  parameter int ES        = 3,
  parameter int FRAC_BW   = 32,
  parameter int TAG_W     = 6,
  parameter int RW        = posit_rw(POSIT_LEN)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sign,
  input  logic signed [RW-1:0]               in_regime,
  input  logic [((ES > 0) ? ES : 1)-1:0]     in_exp,
  input  logic [FRAC_BW-1:0]                 in_frac,
  input  logic                               in_sticky,
  input  logic [1:0]                         in_cls,
  input  logic                               in_ovf,
  input  logic                               in_unf,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [POSIT_LEN-1:0]               out_posit,
  output logic [TAG_W-1:0]                   out_tag,
  output logic                               out_inexact
);

  localparam int EW = (ES > 0) ? ES : 1;
  localparam int BW = POSIT_LEN - 1;
  localparam int TW = EW + FRAC_BW;
  localparam int SW = BW + TW;
  localparam logic [POSIT_LEN-1:0] NAR = POSIT_LEN'(posit_nar(POSIT_LEN));
`ifdef EH2_POSIT_SATURATE_EN
  localparam logic [POSIT_LEN-1:0] MAXPOS = POSIT_LEN'(posit_maxpos(POSIT_LEN));
  localparam logic [POSIT_LEN-1:0] MINPOS = POSIT_LEN'(posit_minpos(POSIT_LEN));
`endif

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_sign_q, s1_sign_d, s1_g_q, s1_g_d, s1_s_q, s1_s_d;
  logic s1_ovf_q, s1_ovf_d, s1_unf_q, s1_unf_d;
  logic [1:0]           s1_cls_q, s1_cls_d;
  logic [BW-1:0]        s1_body_q, s1_body_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
  logic [POSIT_LEN-1:0] out_posit_q, out_posit_d;
  logic                 out_inexact_q, out_inexact_d;

  logic in_fire, s1_adv, s2_adv;
  logic [TW-1:0] tail;
  logic [SW-1:0] stream;
  int            run, rlen;
  logic          term;
  logic [BW-1:0] body_rnd;
  logic          rnd_sat;
  logic [POSIT_LEN-1:0] mag, res_posit;
  logic          res_inexact;

  assign out_valid = s2_valid_q & ~rst;
  assign s2_adv    = out_valid & out_ready;
  assign s1_adv    = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = ~rst & ~flush & (~s1_valid_q | s1_adv);
  assign in_fire   = in_valid & in_ready;

  if (ES > 0) begin : g_tail_exp
    assign tail = {in_exp, in_frac};
  end else begin : g_tail_noexp
    assign tail = {in_frac, 1'b0};
  end

  // Regime run is clamped to the body width; a clamped run has no terminator.
  always_comb begin
    run  = in_regime[RW-1] ? -int'(in_regime) : int'(in_regime) + 1;
    term = 1'b1;
    rlen = run + 1;
    if (run >= BW) begin
      run  = BW;
      rlen = BW;
      term = 1'b0;
    end
    stream = {tail, {BW{1'b0}}} >> rlen;
    if (!in_regime[RW-1]) begin
      stream = stream | ~({SW{1'b1}} >> run);
    end else if (term) begin
      stream = stream | (SW'(1) << (SW - rlen));
    end
  end

  always_comb begin
    s1_sign_d = s1_sign_q;
    s1_body_d = s1_body_q;
    s1_g_d    = s1_g_q;
    s1_s_d    = s1_s_q;
    s1_cls_d  = s1_cls_q;
    s1_ovf_d  = s1_ovf_q;
    s1_unf_d  = s1_unf_q;
    s1_tag_d  = s1_tag_q;
    if (in_fire) begin
      s1_sign_d = in_sign;
      s1_body_d = stream[SW-1 -: BW];
      s1_g_d    = stream[TW-1];
      s1_s_d    = (|stream[TW-2:0]) | in_sticky;
      s1_cls_d  = in_cls;
      s1_ovf_d  = in_ovf;
      s1_unf_d  = in_unf;
      s1_tag_d  = in_tag;
    end
  end

  eh2_posit_round_rne #(.BW(BW)) u_round (
    .body     (s1_body_q),
    .guard    (s1_g_q),
    .sticky   (s1_s_q),
    .body_rnd (body_rnd),
    .sat      (rnd_sat)
  );

  always_comb begin
    mag         = {1'b0, body_rnd};
    res_posit   = s1_sign_q ? (~mag + POSIT_LEN'(1)) : mag;
    res_inexact = s1_g_q | s1_s_q | rnd_sat;
    if (s1_cls_q == CLS_NAR) begin
      res_posit   = NAR;
      res_inexact = 1'b0;
    end else if (s1_cls_q == CLS_ZERO) begin
      res_posit   = '0;
      res_inexact = 1'b0;
    end else if (s1_ovf_q | s1_unf_q) begin
`ifdef EH2_POSIT_SATURATE_EN
      mag         = s1_ovf_q ? MAXPOS : MINPOS;
      res_posit   = s1_sign_q ? (~mag + POSIT_LEN'(1)) : mag;
      res_inexact = 1'b1;
`else
      res_posit   = NAR;
      res_inexact = 1'b0;
`endif
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
    if (flush)       s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s1_adv)      s2_valid_d = 1'b1;
    else if (s2_adv) s2_valid_d = 1'b0;
    if (flush)       s2_valid_d = 1'b0;

    out_posit_d   = s1_adv ? res_posit   : out_posit_q;
    out_inexact_d = s1_adv ? res_inexact : out_inexact_q;
    out_tag_d     = s1_adv ? s1_tag_q    : out_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_body_q     <= '0;
      s1_g_q        <= 1'b0;
      s1_s_q        <= 1'b0;
      s1_cls_q      <= '0;
      s1_ovf_q      <= 1'b0;
      s1_unf_q      <= 1'b0;
      s1_tag_q      <= '0;
      out_posit_q   <= '0;
      out_inexact_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_body_q     <= s1_body_d;
      s1_g_q        <= s1_g_d;
      s1_s_q        <= s1_s_d;
      s1_cls_q      <= s1_cls_d;
      s1_ovf_q      <= s1_ovf_d;
      s1_unf_q      <= s1_unf_d;
      s1_tag_q      <= s1_tag_d;
      out_posit_q   <= out_posit_d;
      out_inexact_q <= out_inexact_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign out_posit   = out_posit_q;
  assign out_tag     = out_tag_q;
  assign out_inexact = out_inexact_q;

endmodule
